// File: rtl/vga_sync_gen_if.sv
// Bundle of VGA timing outputs: sync pulses to the connector plus
// coordinate, video-enable and frame strobes for the renderer/game logic.
interface vga_sync_gen_if;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       frame_start;
  logic       vblank_tick;

  modport master (
    output hsync, vsync, video_on, pixel_x, pixel_y, frame_start, vblank_tick
  );

  modport slave (
    input hsync, vsync, video_on, pixel_x, pixel_y, frame_start, vblank_tick
  );
endinterface

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: wrapping h/v counters with a single
// registered decode stage so every output describes the same coordinate.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_wrap;

  assign h_wrap = (h_cnt == H_LAST);

  // v_cnt only moves on the h wrap, so vsync changes exactly at line start.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      if (v_cnt == V_LAST) begin
        v_cnt <= '0;
      end else begin
        v_cnt <= v_cnt + 10'd1;
      end
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vga.hsync       <= ~SYNC_POL;
      vga.vsync       <= ~SYNC_POL;
      vga.video_on    <= 1'b0;
      vga.pixel_x     <= '0;
      vga.pixel_y     <= '0;
      vga.frame_start <= 1'b0;
      vga.vblank_tick <= 1'b0;
    end else begin
      vga.pixel_x     <= h_cnt;
      vga.pixel_y     <= v_cnt;
      vga.video_on    <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
      vga.hsync       <= ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vga.vsync       <= ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? SYNC_POL : ~SYNC_POL;
      vga.frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
      vga.vblank_tick <= (h_cnt == 10'd0) && (v_cnt == V_VIS);
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-size instance for reset/line timing, shrunken
// instances (both sync polarities) for frame-level and wrap behaviour.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_full;
  logic rst_small;
  int   cycle = 0;
  int   rel_full;
  int   rel_small;
  int   checks = 0;
  int   errors = 0;

  always #20 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  vga_sync_gen_if if_full ();
  vga_sync_gen_if if_s0 ();
  vga_sync_gen_if if_s1 ();

  vga_sync_gen dut_full (
    .clk   (clk),
    .reset (rst_full),
    .vga   (if_full)
  );

  vga_sync_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_s0 (
    .clk   (clk),
    .reset (rst_small),
    .vga   (if_s0)
  );

  vga_sync_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
  ) dut_s1 (
    .clk   (clk),
    .reset (rst_small),
    .vga   (if_s1)
  );

  typedef struct {
    int         cyc;
    logic [9:0] px;
    logic [9:0] py;
    logic       von;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       vb;
  } vec_t;

  vec_t vecs[11];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_vec(input string tag, input logic [9:0] px, input logic [9:0] py,
                           input logic von, input logic hs, input logic vs,
                           input logic fs, input logic vb, input vec_t e);
    check_output({tag, ".pixel_x"}, 32'(px), 32'(e.px));
    check_output({tag, ".pixel_y"}, 32'(py), 32'(e.py));
    check_output({tag, ".video_on"}, 32'(von), 32'(e.von));
    check_output({tag, ".hsync"}, 32'(hs), 32'(e.hs));
    check_output({tag, ".vsync"}, 32'(vs), 32'(e.vs));
    check_output({tag, ".frame_start"}, 32'(fs), 32'(e.fs));
    check_output({tag, ".vblank_tick"}, 32'(vb), 32'(e.vb));
  endtask

  // Advance the full-size instance to k clocks after its reset release.
  task automatic apply_stimulus(input int k);
    while ((cycle - rel_full) < k) @(negedge clk);
  endtask

  task automatic check_full(input string tag, input vec_t e);
    check_vec(tag, if_full.pixel_x, if_full.pixel_y, if_full.video_on, if_full.hsync,
              if_full.vsync, if_full.frame_start, if_full.vblank_tick, e);
  endtask

  task automatic check_s0(input string tag, input vec_t e);
    check_vec(tag, if_s0.pixel_x, if_s0.pixel_y, if_s0.video_on, if_s0.hsync,
              if_s0.vsync, if_s0.frame_start, if_s0.vblank_tick, e);
  endtask

  task automatic check_s1(input string tag, input vec_t e);
    check_vec(tag, if_s1.pixel_x, if_s1.pixel_y, if_s1.video_on, if_s1.hsync,
              if_s1.vsync, if_s1.frame_start, if_s1.vblank_tick, e);
  endtask

  initial begin
    vec_t rst_lo;
    vec_t rst_hi;
    vec_t origin;

    // k = clocks after release; output shows h=(k-1)%800, v=(k-1)/800
    vecs[0]  = '{1,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{2,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{640,  10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{641,  10'd640, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{656,  10'd655, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{657,  10'd656, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{752,  10'd751, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{753,  10'd752, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{800,  10'd799, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{801,  10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1601, 10'd0,   10'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    rst_lo = '{0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    rst_hi = '{0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    origin = '{0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    rst_full  = 1'b1;
    rst_small = 1'b1;
    repeat (5) @(negedge clk);
    check_full("reset_full", rst_lo);
    check_s0("reset_s0", rst_lo);
    check_s1("reset_s1", rst_hi);

    rst_full  = 1'b0;
    rst_small = 1'b0;
    rel_full  = cycle;
    rel_small = cycle;

    fork
      begin : full_branch
        int von_cnt;
        int hs_cnt;
        int hs_first;
        int hs_last;
        logic [9:0] last_px;
        logic [9:0] last_py;

        for (int i = 0; i < 11; i++) begin
          apply_stimulus(vecs[i].cyc);
          check_full($sformatf("vec%0d", i), vecs[i]);
        end

        von_cnt  = 0;
        hs_cnt   = 0;
        hs_first = -1;
        hs_last  = -1;
        last_px  = '0;
        last_py  = '0;
        for (int j = 0; j < 800; j++) begin
          if (if_full.video_on) von_cnt++;
          if (!if_full.hsync) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = int'(if_full.pixel_x);
            hs_last = int'(if_full.pixel_x);
          end
          last_px = if_full.pixel_x;
          last_py = if_full.pixel_y;
          @(negedge clk);
        end
        check_output("line_video_on_clocks", 32'(von_cnt), 32'd640);
        check_output("line_hsync_low_clocks", 32'(hs_cnt), 32'd96);
        check_output("line_hsync_first_x", 32'(hs_first), 32'd656);
        check_output("line_hsync_last_x", 32'(hs_last), 32'd751);
        check_output("line_end_x", 32'(last_px), 32'd799);
        check_output("line_end_y", 32'(last_py), 32'd2);
        check_output("line_wrap_x", 32'(if_full.pixel_x), 32'd0);
        check_output("line_wrap_y", 32'(if_full.pixel_y), 32'd3);

        apply_stimulus(2701);
        check_output("midrst_at_x", 32'(if_full.pixel_x), 32'd300);
        check_output("midrst_at_y", 32'(if_full.pixel_y), 32'd3);
        rst_full = 1'b1;
        @(negedge clk);
        check_full("midrst_full", rst_lo);
        rst_full = 1'b0;
        @(negedge clk);
        check_full("midrst_release_full", origin);
      end

      begin : small_branch
        int fs_cyc[$];
        int vb_cyc[$];
        int last_line;
        int line_bad;
        int pol_bad;
        int pulse_bad;
        int pair_bad;
        int vs_low;
        int hs_low;
        int wrap_seen;
        int wrap_bad;
        int k_rst;
        int gap;
        logic [9:0] px;
        logic [9:0] py;
        logic [9:0] ppx;
        logic [9:0] ppy;

        last_line = 0;
        line_bad  = 0;
        pol_bad   = 0;
        pulse_bad = 0;
        pair_bad  = 0;
        vs_low    = 0;
        hs_low    = 0;
        wrap_seen = 0;
        wrap_bad  = 0;
        ppx       = '0;
        ppy       = '0;

        // Three shrunken frames of 98 clocks (14 x 7)
        for (int k = 1; k <= 294; k++) begin
          @(negedge clk);
          px = if_s0.pixel_x;
          py = if_s0.pixel_y;
          if (k == 1) check_s0("release_s0", origin);
          if (if_s0.frame_start) begin
            fs_cyc.push_back(k);
            if (!(px == 10'd0 && py == 10'd0)) pulse_bad++;
          end
          if (if_s0.vblank_tick) begin
            vb_cyc.push_back(k);
            if (!(px == 10'd0 && py == 10'd4)) pulse_bad++;
          end
          if (if_s0.frame_start && if_s0.vblank_tick) pulse_bad++;
          if (px == 10'd0) begin
            if (k > 1 && (k - last_line) != 14) line_bad++;
            last_line = k;
          end
          if (!if_s0.vsync) begin
            vs_low++;
            if (py != 10'd5) pol_bad++;
          end
          if (!if_s0.hsync) begin
            hs_low++;
            if (px < 10'd10 || px > 10'd12) pol_bad++;
          end
          if (if_s1.hsync !== (px >= 10'd10 && px <= 10'd12)) pol_bad++;
          if (if_s1.vsync !== (py == 10'd5)) pol_bad++;
          if (if_s0.video_on !== (px < 10'd8 && py < 10'd4)) pair_bad++;
          if (if_s1.pixel_x !== px || if_s1.pixel_y !== py) pair_bad++;
          if (k > 1 && ppx == 10'd13 && ppy == 10'd6) begin
            wrap_seen++;
            if (!(px == 10'd0 && py == 10'd0 && if_s0.frame_start)) wrap_bad++;
          end
          ppx = px;
          ppy = py;
        end

        check_output("small_fs_count", 32'(fs_cyc.size()), 32'd3);
        check_output("small_fs_period1", fs_cyc.size() >= 2 ? 32'(fs_cyc[1] - fs_cyc[0]) : 32'd0, 32'd98);
        check_output("small_fs_period2", fs_cyc.size() >= 3 ? 32'(fs_cyc[2] - fs_cyc[1]) : 32'd0, 32'd98);
        check_output("small_vb_count", 32'(vb_cyc.size()), 32'd3);
        check_output("small_vb_first", vb_cyc.size() >= 1 ? 32'(vb_cyc[0]) : 32'd0, 32'd57);
        check_output("small_vb_period1", vb_cyc.size() >= 2 ? 32'(vb_cyc[1] - vb_cyc[0]) : 32'd0, 32'd98);
        check_output("small_vb_period2", vb_cyc.size() >= 3 ? 32'(vb_cyc[2] - vb_cyc[1]) : 32'd0, 32'd98);
        check_output("small_line_period_errs", 32'(line_bad), 32'd0);
        check_output("small_sync_window_errs", 32'(pol_bad), 32'd0);
        check_output("small_pulse_pos_errs", 32'(pulse_bad), 32'd0);
        check_output("small_decode_errs", 32'(pair_bad), 32'd0);
        check_output("small_vsync_low_clocks", 32'(vs_low), 32'd42);
        check_output("small_hsync_low_clocks", 32'(hs_low), 32'd63);
        check_output("small_wrap_seen", 32'(wrap_seen), 32'd2);
        check_output("small_wrap_errs", 32'(wrap_bad), 32'd0);

        // Frame 4 starts at k=295; (5,3) is 47 clocks into it
        k_rst = 295 + 47;
        while ((cycle - rel_small) < k_rst) @(negedge clk);
        check_output("small_midrst_at_x", 32'(if_s0.pixel_x), 32'd5);
        check_output("small_midrst_at_y", 32'(if_s0.pixel_y), 32'd3);
        rst_small = 1'b1;
        @(negedge clk);
        check_s0("midrst_s0", rst_lo);
        check_s1("midrst_s1", rst_hi);
        rst_small = 1'b0;
        @(negedge clk);
        check_s0("midrst_release_s0", origin);
        gap = 0;
        for (int n = 1; n <= 200; n++) begin
          @(negedge clk);
          if (if_s0.frame_start) begin
            gap = n;
            break;
          end
        end
        check_output("small_midrst_next_fs", 32'(gap), 32'd98);
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates 640x480 @ 60 Hz VGA timing from the 25 MHz pixel clock produced by the pixel-clock PLL stage. It runs horizontal and vertical counters and drives HSYNC/VSYNC to the DAC/connector. It also provides the current pixel coordinate and active-video flag to the pixel renderer, plus a per-frame tick to the game-logic update. All outputs are registered and aligned with each other.

## Interface
Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  pixel clock (25 MHz PLL c0 output); all logic on rising edge
- reset  in  1  synchronous, active-high reset
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_on  out  1  high while the (pixel_x, pixel_y) output is inside the visible area
- pixel_x  out  10  horizontal count, 0..H_TOTAL-1
- pixel_y  out  10  vertical count, 0..V_TOTAL-1
- frame_start  out  1  one-clock pulse at coordinate (0,0)
- vblank_tick  out  1  one-clock pulse at (0, V_VISIBLE); game-logic update strobe

## Operation
- Derived values: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525). Both totals must be ≤ 1024. Counters are 10 bits, unsigned.
- Internal h_cnt increments by 1 every clock. When h_cnt = H_TOTAL-1, it wraps to 0 and v_cnt advances.
- v_cnt wraps from V_TOTAL-1 to 0 when h_cnt also wraps. v_cnt never changes mid-line.
- Each clock, the output register loads values decoded from the current (h_cnt, v_cnt):
  - pixel_x = h_cnt, pixel_y = v_cnt
  - video_on = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE)
  - hsync = SYNC_POL when H_VISIBLE+H_FP ≤ h_cnt < H_VISIBLE+H_FP+H_SYNC, else ~SYNC_POL
  - vsync = SYNC_POL when V_VISIBLE+V_FP ≤ v_cnt < V_VISIBLE+V_FP+V_SYNC, else ~SYNC_POL; it is line-aligned and switches together with pixel_x = 0
  - frame_start = (h_cnt==0 && v_cnt==0)
  - vblank_tick = (h_cnt==0 && v_cnt==V_VISIBLE)
- No state machine beyond the two wrapping counters. The porch and sync regions are pure decodes.

## Timing
- Reset, on any clock edge with reset=1, including mid-frame:
  - h_cnt=0, v_cnt=0
  - hsync=~SYNC_POL, vsync=~SYNC_POL
  - video_on=0, pixel_x=0, pixel_y=0, frame_start=0, vblank_tick=0
  - Mid-frame reset abandons the current frame. There is no partial-line completion.
- First edge with reset=0: outputs take the decode of (0,0), so video_on=1 and frame_start=1. h_cnt becomes 1.
- Latency from counter to outputs is exactly 1 clock. All seven outputs always describe the same coordinate; no output is skewed relative to another.
- Line period: exactly H_TOTAL clocks. Frame period: exactly H_TOTAL*V_TOTAL clocks (420000).
- frame_start and vblank_tick are each high for exactly one clock per frame and are never high together.
- Wrap case: the (H_TOTAL-1, V_TOTAL-1) → (0,0) transition is seamless, with no extra or missing cycle.

## Test plan
- Reset release: hold reset 5 clocks, then check all outputs equal their reset values. On the first edge after release, require pixel_x=0, pixel_y=0, video_on=1, frame_start=1, hsync=1, vsync=1.
- Horizontal timing: over one line, require:
  - video_on high for exactly 640 clocks
  - hsync low for exactly 96 clocks, starting when pixel_x=656 and ending after pixel_x=751
  - pixel_x=799 followed by 0, with pixel_y incremented
- Vertical timing: over one frame, require:
  - vsync low for exactly 1600 clocks, covering lines 490–491
  - pixel_y=524 at pixel_x=799 is followed by (0,0) with frame_start=1
  - vblank_tick=1 exactly once, at (0,480)
- Periodicity: across three frames, require consecutive frame_start pulses exactly 420000 clocks apart, and vblank_tick pulses also 420000 clocks apart.
- Mid-frame reset: assert reset for 1 clock at (300,200). Require reset outputs on that edge. On the next edge require (0,0) with frame_start=1, and the next frame_start exactly 420000 clocks later.
- Parameter override: set H_VISIBLE=8, H_FP=2, H_SYNC=3, H_BP=1, V_VISIBLE=4, V_FP=1, V_SYNC=1, V_BP=1. Require line period 14, frame period 98, and hsync asserted at pixel_x 10–12. With SYNC_POL=1, require hsync high only in that window.
